n_slot_break_dvr: RTL
=====================

Name: n_slot_break_dvr

Overview:
- Parametrised, data-carrying successor to the one-slot dataless break-DVR buffer.
- NUM_SLOTS-deep circular elastic buffer. Breaks the combinational paths on data, valid and ready: ins_ready, outs_valid and outs are all driven from registers only.
- Inserted on handshake channels to cut timing paths. Sustains full throughput when NUM_SLOTS >= 2.
- NUM_SLOTS = 1 gives the legacy alternating, 50% throughput behaviour.

Parameters:
- DATA_WIDTH, 32, payload width in bits; legal range >= 1.
- NUM_SLOTS, 2, buffer depth; legal range >= 1.

Ports:
- clk  in  1  clock. Reset rst is synchronous, active-high; clock is clk.
- rst  in  1  synchronous active-high reset.
- ins  in  DATA_WIDTH  input payload.
- ins_valid  in  1  input valid.
- ins_ready  out  1  input ready, registered.
- outs  out  DATA_WIDTH  output payload, equal to mem[head].
- outs_valid  out  1  output valid, registered.
- outs_ready  in  1  output ready.
- occupancy  out  CNT_W  present only with N_SLOT_BREAK_DVR_OCCUPANCY_EN.

Behaviour:
- State:
  - mem[NUM_SLOTS], not reset.
  - head and tail pointers, PTR_W = max(1, clog2(NUM_SLOTS)).
  - count, CNT_W = clog2(NUM_SLOTS+1).
  - readyReg and validReg.
- Reset (rst=1 at posedge): head=0, tail=0, count=0, readyReg=1, validReg=0. Outputs after reset: ins_ready=1, outs_valid=0, outs don't-care.
- Reset mid-operation discards all stored tokens. No token is emitted in the cycle after reset.
- Handshake events:
  - push = ins_valid & ins_ready.
  - pop = outs_valid & outs_ready.
- On push: mem[tail] <= ins; tail advances.
- On pop: head advances.
- Pointer wrap: a pointer equal to NUM_SLOTS-1 goes to 0. Non-power-of-2 depths are legal.
- count_next = count + push - pop.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Simultaneous push and pop on an empty buffer is impossible, because outs_valid=0.
- readyReg <= (count_next < NUM_SLOTS); validReg <= (count_next > 0).
- Invariants: ins_ready == (count < NUM_SLOTS) and outs_valid == (count > 0) hold every cycle.
- No combinational path from ins_valid or outs_ready to any output.
- Latency: a token pushed at edge k is visible on outs with outs_valid=1 after edge k; minimum one cycle.
- Order: strict FIFO.
- Full (count=NUM_SLOTS): ins_ready=0. A pop during full re-raises ins_ready at the next edge, not the same cycle. Full-throughput requirement is therefore NUM_SLOTS >= 2.
- NUM_SLOTS=1: ready and valid alternate, giving a token every 2 cycles.
- outs_valid, once asserted, stays high with stable outs until pop (AXI-style persistence).
- ins_valid asserted while ins_ready=0: ignored, no state change.

Optional Feature:
- Macro: N_SLOT_BREAK_DVR_OCCUPANCY_EN.
- Defined: adds output port occupancy = count, registered and CNT_W wide. Reset value 0.
- Undefined: port absent, no extra logic. The core handshake behaviour is identical either way.

Decomposition:
- Shared package handshake_pkg:
  - clog2 function.
  - Derived width helpers PTR_W and CNT_W.
  - Localparam computations reusable by the other buffers.
- One natural sub-module: break_dvr_wrap_ptr.
  - Parametrised modulo-NUM_SLOTS pointer.
  - Inputs: clk, rst, inc. Output: ptr.
  - Instantiated twice, once for head and once for tail.

Test Plan:
- Reset mid-stream: NUM_SLOTS=4, push 0xA, 0xB, then assert rst for 1 cycle. Required: ins_ready=1, outs_valid=0, occupancy=0 after the reset edge; no 0xA emitted.
- Fill and wrap, NUM_SLOTS=3:
  - Push 1, 2, 3 with outs_ready=0: ins_ready drops the cycle after the 3rd push; a 4th ins_valid is ignored.
  - Then set outs_ready=1: emits 1, 2, 3 in order; ins_ready returns 1 the cycle after the first pop.
  - Push 4, 5 afterwards: pointer wrap, output 4, 5.
- Full throughput, NUM_SLOTS=2: ins_valid=1 and outs_ready=1 continuously with data 0..99. Required: 100 tokens in 101 cycles, ins_ready and outs_valid stay high after the first cycle, no loss.
- Legacy mode, NUM_SLOTS=1, DATA_WIDTH=8: continuous valid/ready with 0x55, 0x66. Required: outs_valid toggles 0,1,0,1; one token per 2 cycles, matching the old dataless behaviour.
- Backpressure stability: NUM_SLOTS=2, outs_ready random 30%, ins_valid random 70%, 1000 tokens.
  - Outputs must equal the scoreboard FIFO order.
  - outs must be held stable while outs_valid & ~outs_ready.
  - count never exceeds 2.
- Simultaneous at full: NUM_SLOTS=2 full with 7, 8; ins_valid=1 with 9, outs_ready=1.
  - No push that cycle, since ins_ready=0; pop of 7.
  - Next cycle ins_ready=1, push 9.
  - Output order 7, 8, 9.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared width helpers for the handshake buffers. Elastic buffers derive their
// pointer and occupancy widths from their depth with these functions.
package handshake_pkg;

   // Smallest r with 2**r >= value; clog2(1) == 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // A pointer always has at least one bit, even for a single-slot buffer.
   function automatic int ptr_w(input int num_slots);
      int w;
      w = clog2(num_slots);
      return (w < 1) ? 1 : w;
   endfunction

   // Occupancy must represent 0..num_slots inclusive.
   function automatic int cnt_w(input int num_slots);
      return clog2(num_slots + 1);
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/break_dvr_wrap_ptr.sv
// Modulo-NUM_SLOTS circular pointer: advances on inc, wraps from NUM_SLOTS-1 to 0.
// Works for non-power-of-two depths.
module break_dvr_wrap_ptr #(
   parameter int NUM_SLOTS = 2,
   parameter int PTR_W     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_SLOTS - 1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] ptr_next;

   always_comb begin
      ptr_next = ptr;
      if (inc) begin
         if (ptr == LAST) ptr_next = '0;
         else             ptr_next = ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else     ptr <= ptr_next;
   end

endmodule

// File: rtl/n_slot_break_dvr.sv
// NUM_SLOTS-deep elastic buffer with registered ins_ready, outs_valid and outs.
// Optional occupancy output enabled by defining N_SLOT_BREAK_DVR_OCCUPANCY_EN.
module n_slot_break_dvr
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLOTS  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       ins,
   input  logic                        ins_valid,
   output logic                        ins_ready,
   output logic [DATA_WIDTH-1:0]       outs,
   output logic                        outs_valid,
   input  logic                        outs_ready
`ifdef N_SLOT_BREAK_DVR_OCCUPANCY_EN
   ,
   output logic [cnt_w(NUM_SLOTS)-1:0] occupancy
`endif
);

   localparam int PTR_W = ptr_w(NUM_SLOTS);
   localparam int CNT_W = cnt_w(NUM_SLOTS);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             ready_reg;
   logic             valid_reg;
   logic             push;
   logic             pop;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. The source keeps valid and data steady until accepted; this
   // buffer holds outs_valid and outs steady until popped. ready/valid here
   // never depend combinationally on the opposite side.
   assign push = ins_valid & ready_reg;
   assign pop  = valid_reg & outs_ready;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   // Flags are recomputed from the next count so they are pure flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         ready_reg <= 1'b1;
         valid_reg <= 1'b0;
      end else begin
         count     <= count_next;
         ready_reg <= (count_next < FULL_CNT);
         valid_reg <= (count_next != '0);
      end
   end

   break_dvr_wrap_ptr #(
      .NUM_SLOTS (NUM_SLOTS),
      .PTR_W     (PTR_W)
   ) u_head_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop),
      .ptr (head)
   );

   break_dvr_wrap_ptr #(
      .NUM_SLOTS (NUM_SLOTS),
      .PTR_W     (PTR_W)
   ) u_tail_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push),
      .ptr (tail)
   );

   // Payload storage is not reset; validity is tracked by count alone.
   generate
      if (NUM_SLOTS == 1) begin : g_one_slot
         logic [DATA_WIDTH-1:0] slot;
         always_ff @(posedge clk) begin
            if (push) slot <= ins;
         end
         assign outs = slot;
      end else begin : g_multi_slot
         logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
         always_ff @(posedge clk) begin
            if (push) mem[tail] <= ins;
         end
         assign outs = mem[head];
      end
   endgenerate

   assign ins_ready  = ready_reg;
   assign outs_valid = valid_reg;

`ifdef N_SLOT_BREAK_DVR_OCCUPANCY_EN
   assign occupancy = count;
`endif

endmodule
